// File: rtl/encoder8_3_seq_if.sv
// encoder8_3_seq_if
//   Handshake bundle for the sequential 8-to-3 encoder.
//   Upstream side: in_valid / in_ready / d (request mask, N = 2**W bits).
//   Downstream side: out_valid / out_ready / code / out_last.
//   Status: cnt (set bits in the captured mask), zero_err (empty-mask pulse).
//   Modports:
//     master - the environment: drives mask and out_ready, observes the rest
//     slave  - the encoder: receives mask and out_ready, drives the rest
interface encoder8_3_seq_if #(
  parameter int W = 3
) ();
  localparam int N = 1 << W;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] code;
  logic         out_last;
  logic [W:0]   cnt;
  logic         zero_err;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, code, out_last, cnt, zero_err
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, code, out_last, cnt, zero_err
  );
endinterface

// File: rtl/encoder8_3_seq.sv
// encoder8_3_seq
//   Sequential encoder: captures an N-bit request mask and hands out the
//   binary index of every set bit, one per output handshake, then goes back
//   to accepting the next mask.
//   Ports:
//     clk  - single clock, all state on the rising edge
//     rst  - synchronous, active-high reset
//     bus  - encoder8_3_seq_if.slave (mask in, codes out, cnt, zero_err)
//   Build option:
//     ENC_ROUND_ROBIN_EN - when defined, the search for the next set bit
//     starts just above the last granted code and wraps; otherwise the
//     lowest set index always wins.
//
//   state | meaning
//   IDLE  | ready for a mask; no code offered
//   EMIT  | offering codes from the pending mask until the last one is taken
module encoder8_3_seq #(
  parameter int W = 3
) (
  input  logic             clk,
  input  logic             rst,
  encoder8_3_seq_if.slave  bus
);
  localparam int N = 1 << W;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q;
  logic [N-1:0] pending_q;
  logic [W:0]   cnt_q;
  logic         zero_err_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [W-1:0] start;
  logic [W-1:0] idx;
  logic [W-1:0] sel;
  logic         last;

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q;
  // ptr_q resets to N-1 so the first search begins at index 0.
  assign start = ptr_q + W'(1);
`else
  assign start = '0;
`endif

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {{W{1'b0}}, v[i]};
    return c;
  endfunction

  // Walk the circular search order backwards so the final assignment is the
  // first set bit at or after 'start'.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = start + W'(k);
      if (pending_q[idx]) sel = idx;
    end
  end

  assign last = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cnt_q       <= '0;
      zero_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q       <= '1;
`endif
    end else begin
      zero_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            pending_q <= bus.d;
            cnt_q     <= popcnt(bus.d);
            if (bus.d != '0) begin
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              zero_err_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pending_q[sel] <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q          <= sel;
`endif
            if (last) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // pending_q is empty whenever IDLE, so code/out_last read 0 there.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.code      = sel;
  assign bus.out_last  = last;
  assign bus.cnt       = cnt_q;
  assign bus.zero_err  = zero_err_q;
endmodule

// File: tb/tb_encoder8_3_seq.sv
// tb_encoder8_3_seq
//   Self-checking bench for encoder8_3_seq. The reference model lists the
//   set bits of a mask in grant order (ascending, or circular from ptr+1 in
//   the round-robin build) and tracks the pointer as "last code granted".
module tb_encoder8_3_seq;
  localparam int W = 3;
  localparam int N = 1 << W;

  logic clk;
  logic rst;

  encoder8_3_seq_if #(.W(W)) bus ();

  encoder8_3_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  int           ref_ptr;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         last_q[$];
  int           viol;
  int           cycles;
  logic         timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant order of a mask: scan indices in search order, keep the set ones.
  function automatic void build_exp(input logic [N-1:0] m);
    int idx;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
`ifdef ENC_ROUND_ROBIN_EN
      idx = (ref_ptr + 1 + k) % N;
`else
      idx = k;
`endif
      if (m[idx]) exp_q.push_back(idx[W-1:0]);
    end
  endfunction

  // Drives one mask and collects the codes the consumer accepts.
  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random stalls.
  task automatic run_mask(input logic [N-1:0] m, input int mode);
    logic         done;
    logic         prev_stall;
    logic [W-1:0] pc;
    logic         pl;
    got_q.delete();
    last_q.delete();
    viol = 0;
    cycles = 0;
    timed_out = 1'b0;
    pc = '0;
    pl = 1'b0;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) timed_out = 1'b1;
    bus.in_valid = 1'b1;
    bus.d = m;
    tick();
    bus.in_valid = 1'b0;
    done = 1'b0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.out_ready = ($urandom_range(0, 9) >= 4);
      endcase
      if (prev_stall && (!bus.out_valid || bus.code !== pc || bus.out_last !== pl))
        viol++;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.code);
        last_q.push_back(bus.out_last);
        done = bus.out_last;
        prev_stall = 1'b0;
      end else if (bus.out_valid) begin
        prev_stall = 1'b1;
        pc = bus.code;
        pl = bus.out_last;
      end
      tick();
      cycles++;
    end
    bus.out_ready = 1'b0;
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", bus.code); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_cmp++; if (bus.cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.zero_err !== 1'b0) begin n_fail++; $display("FAIL reset_zero_err got %b want 0", bus.zero_err); end
    rst = 1'b0;
    ref_ptr = N - 1;
  endtask

  task automatic test_basic();
    build_exp(8'b1010_0100);
    run_mask(8'b1010_0100, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", timed_out); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_code[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
        n_cmp++; if (last_q[i] !== (i == exp_q.size() - 1)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, last_q[i], (i == exp_q.size() - 1)); end
      end
    end
    n_cmp++; if (cycles != 3) begin n_fail++; $display("FAIL basic_cycles got %0d want 3", cycles); end
    n_cmp++; if (bus.cnt !== 4'd3) begin n_fail++; $display("FAIL basic_cnt got %0d want 3", bus.cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_after got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_after got %b want 0", bus.out_valid); end
    if (exp_q.size() > 0) ref_ptr = exp_q[exp_q.size() - 1];
  endtask

  task automatic test_zero();
    bus.in_valid = 1'b1;
    bus.d = '0;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.zero_err !== 1'b1) begin n_fail++; $display("FAIL zero_err_pulse got %b want 1", bus.zero_err); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.cnt !== 4'd0) begin n_fail++; $display("FAIL zero_cnt got %0d want 0", bus.cnt); end
    tick();
    n_cmp++; if (bus.zero_err !== 1'b0) begin n_fail++; $display("FAIL zero_err_width got %b want 0", bus.zero_err); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid_later got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    build_exp(8'hFF);
    run_mask(8'hFF, 1);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b want 0", timed_out); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", viol); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_code[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (bus.cnt !== 4'd8) begin n_fail++; $display("FAIL stall_cnt got %0d want 8", bus.cnt); end
    if (exp_q.size() > 0) ref_ptr = exp_q[exp_q.size() - 1];
  endtask

  task automatic test_reset_mid();
    build_exp(8'b0001_1000);
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    bus.in_valid = 1'b1;
    bus.d = 8'b0001_1000;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_first_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.code !== exp_q[0]) begin n_fail++; $display("FAIL rmid_first_code got %0d want %0d", bus.code, exp_q[0]); end
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    ref_ptr = N - 1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_more_codes cycle %0d got out_valid %b want 0", i, bus.out_valid); end
    end
    bus.out_ready = 1'b0;
  endtask

`ifdef ENC_ROUND_ROBIN_EN
  task automatic test_rr();
    logic [N-1:0] masks[4];
    int           want[4][3];
    int           wlen[4];
    masks[0] = 8'b1000_0001; want[0] = '{0, 7, 0}; wlen[0] = 2;
    masks[1] = 8'b1000_0001; want[1] = '{0, 7, 0}; wlen[1] = 2;
    masks[2] = 8'b0000_1000; want[2] = '{3, 0, 0}; wlen[2] = 1;
    masks[3] = 8'b0001_1001; want[3] = '{4, 0, 3}; wlen[3] = 3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_ptr = N - 1;
    for (int t = 0; t < 4; t++) begin
      run_mask(masks[t], 0);
      n_cmp++;
      if (got_q.size() != wlen[t]) begin
        n_fail++; $display("FAIL rr_count[%0d] got %0d want %0d", t, got_q.size(), wlen[t]);
      end else begin
        for (int i = 0; i < wlen[t]; i++) begin
          n_cmp++; if (got_q[i] !== want[t][i][W-1:0]) begin n_fail++; $display("FAIL rr_code[%0d][%0d] got %0d want %0d", t, i, got_q[i], want[t][i]); end
        end
      end
    end
    ref_ptr = 3;
  endtask
`endif

  task automatic test_back_to_back();
    logic [N-1:0] a;
    logic [W-1:0] all_q[$];
    int           caps;
    logic         cap_now;
    logic         got_last2;
    a = N'($urandom_range(1, 255));
    build_exp(a);
    all_q = exp_q;
    if (exp_q.size() > 0) ref_ptr = exp_q[exp_q.size() - 1];
    build_exp(8'h03);
    foreach (exp_q[i]) all_q.push_back(exp_q[i]);
    if (exp_q.size() > 0) ref_ptr = exp_q[exp_q.size() - 1];
    got_q.delete();
    caps = 0;
    viol = 0;
    got_last2 = 1'b0;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    bus.in_valid = 1'b1;
    bus.d = a;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && !got_last2; cyc++) begin
      cap_now = bus.in_valid && bus.in_ready;
      if (bus.in_ready && bus.out_valid) viol++;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.code);
        if (bus.out_last && caps == 2) got_last2 = 1'b1;
      end
      tick();
      if (cap_now) begin
        caps++;
        if (caps == 1) bus.d = 8'h03;
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (got_last2 !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout got %b want 1", got_last2); end
    n_cmp++; if (caps != 2) begin n_fail++; $display("FAIL b2b_captures got %0d want 2", caps); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL b2b_ready_overlap got %0d want 0", viol); end
    n_cmp++;
    if (got_q.size() != all_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), all_q.size());
    end else begin
      for (int i = 0; i < all_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== all_q[i]) begin n_fail++; $display("FAIL b2b_code[%0d] got %0d want %0d", i, got_q[i], all_q[i]); end
      end
    end
    n_cmp++; if (bus.cnt !== 4'd2) begin n_fail++; $display("FAIL b2b_cnt got %0d want 2", bus.cnt); end
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    for (int t = 0; t < 25; t++) begin
      m = N'($urandom_range(0, 255));
      if ((t % 8) == 5) m = '0;
      if (m == '0) begin
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        bus.in_valid = 1'b1;
        bus.d = m;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.zero_err !== 1'b1) begin n_fail++; $display("FAIL rnd_zero_err[%0d] got %b want 1", t, bus.zero_err); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_zero_valid[%0d] got %b want 0", t, bus.out_valid); end
      end else begin
        build_exp(m);
        run_mask(m, 2);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout[%0d] got %b want 0", t, timed_out); end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL rnd_hold[%0d] got %0d want 0", t, viol); end
        n_cmp++; if (bus.cnt !== 4'($countones(m))) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", t, bus.cnt, $countones(m)); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
          n_fail++; $display("FAIL rnd_count[%0d] mask %h got %0d want %0d", t, m, got_q.size(), exp_q.size());
        end else begin
          for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_code[%0d][%0d] mask %h got %0d want %0d", t, i, m, got_q[i], exp_q[i]); end
          end
        end
        if (exp_q.size() > 0) ref_ptr = exp_q[exp_q.size() - 1];
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    ref_ptr = N - 1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.d = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_reset_mid();
`ifdef ENC_ROUND_ROBIN_EN
    test_rr();
`endif
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
